network_rcv: RTL and testbench
==============================

// Module: network_rcv
// PURPOSE
//   Network-layer receiver sitting directly upstream of transportRcv. Accepts link-layer
//   frames one byte at a time. Checks the destination address, length and XOR checksum.
//   Buffers the payload, then replays it to transportRcv as a contiguous rcvSignal/packetIn
//   burst. Bad or foreign frames never reach transport.
//   Frame format: DEST, SRC, LEN, payload[0..LEN-1], CSUM.
//   CSUM = XOR of DEST, SRC, LEN and every payload byte.
// PARAMETERS
//   MY_ADDR  8'h01  station address; 8'hFF (broadcast) is also accepted
//   MAX_LEN  16     max payload bytes (buffer depth); LEN=0 or LEN>MAX_LEN is an error
//   GAP      4      min idle cycles (rcvSignal=0) after each burst
//   TIMEOUT  64     max cycles between bytes inside a frame before abort
// PORTS
//   clk         in   1  system clock, all logic on rising edge
//   reset       in   1  asynchronous, active-low reset
//   byteValid   in   1  byteIn valid this cycle
//   frameStart  in   1  qualified by byteValid; marks DEST byte
//   byteIn      in   8  link byte
//   rcvSignal   out  1  high for exactly LEN cycles while payload is replayed
//   packetIn    out  8  payload byte, valid while rcvSignal=1 (feeds transportRcv.packetIn)
//   srcAddr     out  8  SRC of last delivered frame, stable until next delivery
//   badFrame    out  1  1-cycle pulse on checksum/length/timeout/restart error
//   dropCount   out  8  saturating count of frames lost because replay was busy
// BEHAVIOUR
//   Reset (async, reset=0): all outputs 0, state IDLE, buffer/counters cleared.
//   States: IDLE, SRC, LEN, PAY, CSUM, PLAY, GAPW, SKIP.
//   IDLE: byteValid&frameStart -> latch DEST, csum<=byteIn.
//     If DEST==MY_ADDR|8'hFF -> SRC, else SKIP. Bytes without frameStart are ignored.
//   SRC -> LEN: latch SRC.
//   LEN -> PAY: for 1<=LEN<=MAX_LEN; else pulse badFrame and go to SKIP.
//   PAY: payload written to buffer[idx], idx++. After LEN bytes -> CSUM.
//   In SRC/LEN/PAY/CSUM, each accepted byte XORs into csum.
//   CSUM: byte==csum -> PLAY, srcAddr updated. Mismatch -> badFrame, IDLE.
//   Checksum byte accepted at cycle T: rcvSignal=1 from T+1 through T+LEN.
//     packetIn=buffer[0..LEN-1] in order; registered outputs.
//     rcvSignal is not gated by sessionBusy; transport handles backpressure.
//   GAPW: rcvSignal=0 for exactly GAP cycles, then IDLE.
//   PLAY/GAPW: link bytes ignored. Each byteValid&frameStart seen increments dropCount
//     (saturates at 255). Rest of that frame is ignored because no new frameStart arrives.
//   SKIP: ignore bytes until the next byteValid&frameStart, which is handled as in IDLE.
//   byteValid&frameStart in SRC/LEN/PAY/CSUM: badFrame pulse, current frame aborted.
//     New byte is taken as DEST (same check as IDLE).
//   Timeout: in SRC/LEN/PAY/CSUM, TIMEOUT cycles without byteValid -> badFrame, IDLE.
//   Idle-cycle counter is cleared on every byteValid.
//   Back-to-back bytes (byteValid every cycle) fully supported; no input backpressure.
//   Reset asserted mid-PLAY: rcvSignal drops to 0 immediately (async).
//     Buffer contents are discarded.
// TESTING
//   1 Frame 01,05,02,80,04,82 one byte/cycle -> rcvSignal 2 cycles, packetIn 80 then 04.
//     srcAddr=05; badFrame=0; then >=4 cycles rcvSignal=0.
//   2 Same frame with CSUM=83 -> badFrame pulse 1 cycle after CSUM; rcvSignal stays 0.
//   3 DEST=02 frame, then valid frame to 01 -> first ignored silently; second delivered.
//     Broadcast DEST=FF also delivered.
//   4 LEN=0 and LEN=17 -> badFrame at LEN byte; rest skipped.
//     Next valid frame delivered; 16-byte frame replays all 16 bytes in order.
//   5 frameStart during PLAY -> dropCount 0->1; frame lost; 256 such -> dropCount holds 255.
//   6 Stall 64 cycles after LEN -> badFrame, IDLE.
//     frameStart mid-payload -> abort; new frame delivered.
//     reset low mid-PLAY -> outputs 0 at once.

Source files
------------

// File: rtl/network_rcv.sv
// network_rcv: network-layer receiver that sits directly upstream of transportRcv.
// It accepts link frames one byte at a time in the format DEST, SRC, LEN, payload, CSUM.
// It filters on the destination address, validates the length and the XOR checksum,
// and buffers the payload. A good payload is then replayed as one contiguous
// rcvSignal/packetIn burst, followed by a guaranteed idle gap.
// Bad or foreign frames never reach the transport layer.
module network_rcv #(
  parameter logic [7:0]  MY_ADDR = 8'h01,
  parameter int unsigned MAX_LEN = 16,
  parameter int unsigned GAP     = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       byteValid,
  input  logic       frameStart,
  input  logic [7:0] byteIn,
  output logic       rcvSignal,
  output logic [7:0] packetIn,
  output logic [7:0] srcAddr,
  output logic       badFrame,
  output logic [7:0] dropCount
);

  localparam int unsigned AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned IW = $clog2(MAX_LEN + 1);
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned GW = (GAP > 1) ? $clog2(GAP) : 1;

  localparam logic [IW-1:0] IDX_ONE  = IW'(1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TO_ONE   = TW'(1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);
  localparam logic [GW-1:0] GAP_ONE  = GW'(1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_SRC  = 3'd1;
  localparam logic [2:0] S_LEN  = 3'd2;
  localparam logic [2:0] S_PAY  = 3'd3;
  localparam logic [2:0] S_CSUM = 3'd4;
  localparam logic [2:0] S_PLAY = 3'd5;
  localparam logic [2:0] S_GAPW = 3'd6;
  localparam logic [2:0] S_SKIP = 3'd7;

  // Our own station address or broadcast is accepted.
  function automatic logic dest_ok(input logic [7:0] b);
    dest_ok = (b == MY_ADDR) || (b == 8'hFF);
  endfunction

  // A legal length is 1..MAX_LEN payload bytes.
  function automatic logic len_ok(input logic [7:0] b);
    len_ok = (b != 8'h00) && ({24'h000000, b} <= MAX_LEN);
  endfunction

  logic [2:0]    state_q, state_d;
  logic [7:0]    csum_q, csum_d;
  logic [7:0]    src_q, src_d;
  logic [IW-1:0] len_q, len_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [TW-1:0] idle_q, idle_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          rcv_q, rcv_d;
  logic [7:0]    pkt_q, pkt_d;
  logic [7:0]    srcout_q, srcout_d;
  logic          bad_q, bad_d;
  logic [7:0]    drop_q, drop_d;
  logic [7:0]    mem_q [MAX_LEN];

  logic          sof_s;
  logic          wr_en_s;
  logic [AW-1:0] wr_idx_s;
  logic [IW-1:0] idx_inc_s;

  assign sof_s     = byteValid & frameStart;
  assign idx_inc_s = idx_q + IDX_ONE;

  // Next-state logic for frame parsing, payload replay, gap timing and drop counting.
  always_comb begin
    state_d  = state_q;
    csum_d   = csum_q;
    src_d    = src_q;
    len_d    = len_q;
    idx_d    = idx_q;
    idle_d   = idle_q;
    gap_d    = gap_q;
    rcv_d    = rcv_q;
    pkt_d    = pkt_q;
    srcout_d = srcout_q;
    bad_d    = 1'b0;
    drop_d   = drop_q;
    wr_en_s  = 1'b0;
    wr_idx_s = idx_q[AW-1:0];

    case (state_q)
      S_IDLE, S_SKIP: begin
        if (sof_s) begin
          csum_d  = byteIn;
          idle_d  = '0;
          state_d = dest_ok(byteIn) ? S_SRC : S_SKIP;
        end else begin
          state_d = state_q;
        end
      end

      S_SRC, S_LEN, S_PAY, S_CSUM: begin
        if (byteValid) begin
          idle_d = '0;
          if (frameStart) begin
            // A new frame start mid-frame aborts the current frame and begins a new one.
            bad_d   = 1'b1;
            csum_d  = byteIn;
            state_d = dest_ok(byteIn) ? S_SRC : S_SKIP;
          end else begin
            csum_d = csum_q ^ byteIn;
            case (state_q)
              S_SRC: begin
                src_d   = byteIn;
                state_d = S_LEN;
              end
              S_LEN: begin
                if (len_ok(byteIn)) begin
                  len_d   = byteIn[IW-1:0];
                  idx_d   = '0;
                  state_d = S_PAY;
                end else begin
                  bad_d   = 1'b1;
                  state_d = S_SKIP;
                end
              end
              S_PAY: begin
                wr_en_s = 1'b1;
                if (idx_inc_s == len_q) begin
                  idx_d   = '0;
                  state_d = S_CSUM;
                end else begin
                  idx_d   = idx_inc_s;
                end
              end
              S_CSUM: begin
                if (byteIn == csum_q) begin
                  // The first payload byte goes out on the very next cycle.
                  rcv_d    = 1'b1;
                  pkt_d    = mem_q[0];
                  idx_d    = IDX_ONE;
                  srcout_d = src_q;
                  state_d  = S_PLAY;
                end else begin
                  bad_d   = 1'b1;
                  state_d = S_IDLE;
                end
              end
              default: begin
                state_d = S_IDLE;
              end
            endcase
          end
        end else if (idle_q == TO_LAST) begin
          bad_d   = 1'b1;
          idle_d  = '0;
          state_d = S_IDLE;
        end else begin
          idle_d = idle_q + TO_ONE;
        end
      end

      S_PLAY: begin
        if (idx_q == len_q) begin
          rcv_d   = 1'b0;
          pkt_d   = 8'h00;
          gap_d   = '0;
          state_d = S_GAPW;
        end else begin
          pkt_d   = mem_q[idx_q[AW-1:0]];
          idx_d   = idx_inc_s;
        end
      end

      S_GAPW: begin
        if (gap_q == GAP_LAST) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + GAP_ONE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Frames that start while the replay path is busy are lost; count them, saturating.
    if ((state_q == S_PLAY || state_q == S_GAPW) && sof_s && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end else begin
      drop_d = drop_q;
    end
  end

  // Control and output registers; reset forces every output low immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      csum_q   <= 8'h00;
      src_q    <= 8'h00;
      len_q    <= '0;
      idx_q    <= '0;
      idle_q   <= '0;
      gap_q    <= '0;
      rcv_q    <= 1'b0;
      pkt_q    <= 8'h00;
      srcout_q <= 8'h00;
      bad_q    <= 1'b0;
      drop_q   <= 8'h00;
    end else begin
      state_q  <= state_d;
      csum_q   <= csum_d;
      src_q    <= src_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      idle_q   <= idle_d;
      gap_q    <= gap_d;
      rcv_q    <= rcv_d;
      pkt_q    <= pkt_d;
      srcout_q <= srcout_d;
      bad_q    <= bad_d;
      drop_q   <= drop_d;
    end
  end

  // Payload buffer: written in arrival order and discarded on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(MAX_LEN); i++) begin
        mem_q[i] <= 8'h00;
      end
    end else if (wr_en_s) begin
      mem_q[wr_idx_s] <= byteIn;
    end
  end

  assign rcvSignal = rcv_q;
  assign packetIn  = pkt_q;
  assign srcAddr   = srcout_q;
  assign badFrame  = bad_q;
  assign dropCount = drop_q;

endmodule

// File: tb/tb_network_rcv.sv
// tb_network_rcv: directed frames against a frame-level reference model.
// The model works with whole frames, a replay queue and a busy-until cycle number.
// One compare process checks every cycle, and literal checks pin the key values.
module tb_network_rcv;

  logic       clk;
  logic       reset;
  logic       byteValid;
  logic       frameStart;
  logic [7:0] byteIn;
  logic       rcvSignal;
  logic [7:0] packetIn;
  logic [7:0] srcAddr;
  logic       badFrame;
  logic [7:0] dropCount;

  int n_checks = 0;
  int n_fail   = 0;
  bit checking = 0;

  network_rcv dut (
    .clk        (clk),
    .reset      (reset),
    .byteValid  (byteValid),
    .frameStart (frameStart),
    .byteIn     (byteIn),
    .rcvSignal  (rcvSignal),
    .packetIn   (packetIn),
    .srcAddr    (srcAddr),
    .badFrame   (badFrame),
    .dropCount  (dropCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (frame level) ----------------
  int         cyc = 0;
  int         busy_end = 0;
  int         idle_n = 0;
  bit         collecting = 0;
  logic [7:0] fr[$];
  logic [7:0] play[$];
  logic       m_rcv = 1'b0;
  logic [7:0] m_pkt = 8'h00;
  logic       m_bad = 1'b0;
  logic [7:0] m_src = 8'h00;
  logic [7:0] m_drop = 8'h00;

  always @(posedge clk) begin
    logic [7:0] x;
    cyc++;
    if (!reset) begin
      fr.delete(); play.delete();
      collecting = 0; idle_n = 0; busy_end = 0;
      m_rcv = 1'b0; m_pkt = 8'h00; m_bad = 1'b0; m_src = 8'h00; m_drop = 8'h00;
    end else begin
      m_bad = 1'b0;
      if (cyc <= busy_end) begin
        if (byteValid && frameStart && m_drop != 8'hFF) m_drop = m_drop + 8'd1;
      end else if (byteValid && frameStart) begin
        if (collecting) m_bad = 1'b1;
        fr.delete();
        fr.push_back(byteIn);
        idle_n = 0;
        collecting = (byteIn == 8'h01) || (byteIn == 8'hFF);
      end else if (collecting) begin
        if (byteValid) begin
          idle_n = 0;
          fr.push_back(byteIn);
          if (fr.size() == 3 && (byteIn == 8'h00 || byteIn > 8'd16)) begin
            m_bad = 1'b1;
            collecting = 0;
          end else if (fr.size() >= 4 && fr.size() == int'(fr[2]) + 4) begin
            x = 8'h00;
            for (int i = 0; i < fr.size() - 1; i++) x = x ^ fr[i];
            if (x == byteIn) begin
              for (int i = 3; i < fr.size() - 1; i++) play.push_back(fr[i]);
              m_src = fr[1];
              busy_end = cyc + int'(fr[2]) + 4;
            end else begin
              m_bad = 1'b1;
            end
            collecting = 0;
          end
        end else begin
          idle_n++;
          if (idle_n == 64) begin
            m_bad = 1'b1;
            collecting = 0;
          end
        end
      end
      if (play.size() != 0) begin
        m_rcv = 1'b1;
        m_pkt = play.pop_front();
      end else begin
        m_rcv = 1'b0;
        m_pkt = 8'h00;
      end
    end
  end

  // Per-cycle comparison against the model, sampled on the falling edge.
  always @(negedge clk) begin
    if (checking) begin
      if (!reset) begin
        chk("rst_rcv", 8'(rcvSignal), 8'h00);
        chk("rst_pkt", packetIn, 8'h00);
        chk("rst_bad", 8'(badFrame), 8'h00);
        chk("rst_src", srcAddr, 8'h00);
        chk("rst_drop", dropCount, 8'h00);
      end else begin
        chk("cyc_rcv", 8'(rcvSignal), 8'(m_rcv));
        chk("cyc_bad", 8'(badFrame), 8'(m_bad));
        chk("cyc_src", srcAddr, m_src);
        chk("cyc_drop", dropCount, m_drop);
        if (m_rcv) chk("cyc_pkt", packetIn, m_pkt);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic v, input logic fs, input logic [7:0] b);
    byteValid = v; frameStart = fs; byteIn = b;
    @(negedge clk);
    byteValid = 1'b0; frameStart = 1'b0; byteIn = 8'h00;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic send_frame(input logic [7:0] dest, input logic [7:0] src, input logic [7:0] len,
                            input int npay, input logic [7:0] base, input logic [7:0] cx);
    logic [7:0] cs;
    logic [7:0] p;
    cs = dest ^ src ^ len;
    drive(1'b1, 1'b1, dest);
    drive(1'b1, 1'b0, src);
    drive(1'b1, 1'b0, len);
    for (int i = 0; i < npay; i++) begin
      p = base + 8'(i);
      cs = cs ^ p;
      drive(1'b1, 1'b0, p);
    end
    drive(1'b1, 1'b0, cs ^ cx);
  endtask

  initial begin
    reset = 1'b0; byteValid = 1'b0; frameStart = 1'b0; byteIn = 8'h00;
    repeat (3) @(negedge clk);
    checking = 1;
    chk("reset_rcv", 8'(rcvSignal), 8'h00);
    chk("reset_drop", dropCount, 8'h00);
    reset = 1'b1;
    idle(2);

    // 1: basic frame 01,05,02,80,04,82
    drive(1'b1, 1'b1, 8'h01); drive(1'b1, 1'b0, 8'h05); drive(1'b1, 1'b0, 8'h02);
    drive(1'b1, 1'b0, 8'h80); drive(1'b1, 1'b0, 8'h04); drive(1'b1, 1'b0, 8'h82);
    chk("t1_rcv0", 8'(rcvSignal), 8'h01);
    chk("t1_pkt0", packetIn, 8'h80);
    chk("t1_src", srcAddr, 8'h05);
    chk("t1_bad", 8'(badFrame), 8'h00);
    idle(1);
    chk("t1_pkt1", packetIn, 8'h04);
    idle(1);
    chk("t1_end", 8'(rcvSignal), 8'h00);
    idle(6);

    // 2: bad checksum
    drive(1'b1, 1'b1, 8'h01); drive(1'b1, 1'b0, 8'h05); drive(1'b1, 1'b0, 8'h02);
    drive(1'b1, 1'b0, 8'h80); drive(1'b1, 1'b0, 8'h04); drive(1'b1, 1'b0, 8'h83);
    chk("t2_bad", 8'(badFrame), 8'h01);
    chk("t2_rcv", 8'(rcvSignal), 8'h00);
    idle(1);
    chk("t2_bad_pulse", 8'(badFrame), 8'h00);
    idle(2);

    // 3: foreign, own, broadcast
    send_frame(8'h02, 8'h05, 8'h02, 2, 8'h10, 8'h00);
    chk("t3_foreign_bad", 8'(badFrame), 8'h00);
    chk("t3_foreign_rcv", 8'(rcvSignal), 8'h00);
    send_frame(8'h01, 8'h06, 8'h03, 3, 8'h20, 8'h00);
    chk("t3_own_pkt", packetIn, 8'h20);
    chk("t3_own_src", srcAddr, 8'h06);
    idle(9);
    send_frame(8'hFF, 8'h07, 8'h01, 1, 8'h55, 8'h00);
    chk("t3_bcast_rcv", 8'(rcvSignal), 8'h01);
    chk("t3_bcast_pkt", packetIn, 8'h55);
    idle(7);

    // 4: illegal lengths, then a full 16-byte frame
    drive(1'b1, 1'b1, 8'h01); drive(1'b1, 1'b0, 8'h05); drive(1'b1, 1'b0, 8'h00);
    chk("t4_len0_bad", 8'(badFrame), 8'h01);
    drive(1'b1, 1'b0, 8'h04);
    chk("t4_len0_pulse", 8'(badFrame), 8'h00);
    send_frame(8'h01, 8'h05, 8'd17, 17, 8'h30, 8'h00);
    idle(2);
    send_frame(8'h01, 8'h08, 8'd16, 16, 8'h40, 8'h00);
    chk("t4_full_pkt0", packetIn, 8'h40);
    for (int i = 1; i < 16; i++) begin
      idle(1);
      chk("t4_full_pkt", packetIn, 8'h40 + 8'(i));
    end
    idle(1);
    chk("t4_full_end", 8'(rcvSignal), 8'h00);
    idle(6);

    // 5: frames lost during replay
    send_frame(8'h01, 8'h09, 8'h02, 2, 8'h60, 8'h00);
    drive(1'b1, 1'b1, 8'h01);
    chk("t5_drop1", dropCount, 8'h01);
    drive(1'b1, 1'b0, 8'h09); drive(1'b1, 1'b0, 8'h02); drive(1'b1, 1'b0, 8'hAA);
    drive(1'b1, 1'b0, 8'hBB); drive(1'b1, 1'b0, 8'h19);
    idle(3);
    chk("t5_lost_rcv", 8'(rcvSignal), 8'h00);
    chk("t5_drop_hold", dropCount, 8'h01);
    for (int f = 0; f < 13; f++) begin
      send_frame(8'h01, 8'h0A, 8'd16, 16, 8'h70, 8'h00);
      for (int k = 0; k < 20; k++) drive(1'b1, 1'b1, 8'h01);
    end
    chk("t5_drop_sat", dropCount, 8'hFF);
    idle(2);

    // 6a: timeout boundary, 63 idle cycles survive, 64 abort
    drive(1'b1, 1'b1, 8'h01); drive(1'b1, 1'b0, 8'h05); drive(1'b1, 1'b0, 8'h02);
    idle(63);
    drive(1'b1, 1'b0, 8'h80); drive(1'b1, 1'b0, 8'h04); drive(1'b1, 1'b0, 8'h82);
    chk("t6_to63_rcv", 8'(rcvSignal), 8'h01);
    chk("t6_to63_pkt", packetIn, 8'h80);
    idle(8);
    drive(1'b1, 1'b1, 8'h01); drive(1'b1, 1'b0, 8'h05); drive(1'b1, 1'b0, 8'h02);
    idle(63);
    chk("t6_to_early", 8'(badFrame), 8'h00);
    idle(1);
    chk("t6_to_bad", 8'(badFrame), 8'h01);
    idle(2);

    // 6b: restart mid-payload
    drive(1'b1, 1'b1, 8'h01); drive(1'b1, 1'b0, 8'h05); drive(1'b1, 1'b0, 8'h03);
    drive(1'b1, 1'b0, 8'h11); drive(1'b1, 1'b0, 8'h22);
    drive(1'b1, 1'b1, 8'h01);
    chk("t6_restart_bad", 8'(badFrame), 8'h01);
    drive(1'b1, 1'b0, 8'h09); drive(1'b1, 1'b0, 8'h01); drive(1'b1, 1'b0, 8'h33);
    drive(1'b1, 1'b0, 8'h3A);
    chk("t6_restart_rcv", 8'(rcvSignal), 8'h01);
    chk("t6_restart_pkt", packetIn, 8'h33);
    chk("t6_restart_src", srcAddr, 8'h09);
    idle(6);

    // 6c: reset during replay
    send_frame(8'h01, 8'h0B, 8'd16, 16, 8'hA0, 8'h00);
    idle(2);
    chk("t6_play_before", 8'(rcvSignal), 8'h01);
    #2 reset = 1'b0;
    #1;
    chk("t6_async_rcv", 8'(rcvSignal), 8'h00);
    chk("t6_async_pkt", packetIn, 8'h00);
    chk("t6_async_src", srcAddr, 8'h00);
    chk("t6_async_drop", dropCount, 8'h00);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    idle(2);
    drive(1'b1, 1'b1, 8'h01); drive(1'b1, 1'b0, 8'h05); drive(1'b1, 1'b0, 8'h02);
    drive(1'b1, 1'b0, 8'h80); drive(1'b1, 1'b0, 8'h04); drive(1'b1, 1'b0, 8'h82);
    chk("t6_after_rst_pkt", packetIn, 8'h80);
    idle(8);

    checking = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
